pll_lock_monitor: RTL and testbench

- Receive-side companion to `pll_core`, clocked by the same `clk_in`.
- Samples the divided clock that `pll_core` produces and measures its period in `clk_in` cycles.
- Compares each measured period with the period expected for `div_num`, and asserts `locked` after a run of consecutive good periods.
- Provides the verification and system reference for lock status, independent of the core's own `locked` flag.

---
 rtl/pll_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/pll_lock_monitor.sv | 154 +++++++++++++++
 tb/tb_pll_lock_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Definitions shared between pll_core and its receive-side lock monitor.
package pll_pkg;

  localparam int unsigned DIV_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    LOCKED
  } mon_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for a clock-as-data input, followed by a registered
// single-cycle rising-edge pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/pll_lock_monitor.sv
// Receive-side lock monitor for pll_core: measures the divided clock period in
// clk_in cycles and declares lock after a run of in-tolerance periods.
module pll_lock_monitor
  import pll_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 1,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_num,
  input  logic             clk_mon,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lock_lost,
  output logic             freq_err
);

  localparam int unsigned           MC_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]       MC_LOCK   = MC_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0] TOL_S     = (CNT_W+1)'(TOL);

  mon_state_t r_state;
  mon_state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [MC_W-1:0]  r_mc;
  logic [MC_W-1:0]  w_mc_nxt;
  logic [MC_W-1:0]  w_mc_inc;
  logic [DIV_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_lock_lost;
  logic             r_freq_err;

  logic             w_rise;
  logic             w_idle_req;
  logic             w_cfg_chg;
  logic             w_timeout;
  logic             w_in_tol;
  logic             w_cap;
  logic             w_ferr_set;
  logic [CNT_W-1:0] w_exp;
  logic signed [CNT_W:0] w_diff;

  sync_edge_det u_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_n),
    .i_d     (clk_mon),
    .o_rise  (w_rise)
  );

  assign w_exp      = CNT_W'({div_num, 1'b0});
  assign w_diff     = $signed({1'b0, r_cnt}) - $signed({1'b0, w_exp});
  assign w_in_tol   = (w_diff <= TOL_S) && (w_diff >= -TOL_S);
  assign w_idle_req = !enable || (div_num == '0);
  assign w_cfg_chg  = (div_num != r_div_q) && (r_state != IDLE);
  assign w_timeout  = (r_cnt >= TIMEOUT_C);
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_mc_inc   = r_mc + 1'b1;

  // Priority: idle request, then config change, then edge, then timeout.
  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_mc_nxt   = r_mc;
    w_cap      = 1'b0;
    w_ferr_set = 1'b0;
    if (w_idle_req) begin
      w_next    = IDLE;
      w_cnt_nxt = '0;
      w_mc_nxt  = '0;
    end else if (w_cfg_chg) begin
      w_next    = ACQUIRE;
      w_cnt_nxt = '0;
      w_mc_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: w_next = ACQUIRE;
        ACQUIRE: begin
          if (w_rise) begin
            w_next    = MEASURE;
            w_cnt_nxt = CNT_W'(1);
            w_mc_nxt  = '0;
          end
        end
        MEASURE, LOCKED: begin
          if (w_rise) begin
            w_cap     = 1'b1;
            w_cnt_nxt = CNT_W'(1);
            if (w_in_tol) begin
              if (r_state == MEASURE) begin
                w_mc_nxt = w_mc_inc;
                if (w_mc_inc == MC_LOCK) w_next = LOCKED;
              end
            end else begin
              w_next     = MEASURE;
              w_mc_nxt   = '0;
              w_ferr_set = 1'b1;
            end
          end else if (w_timeout) begin
            w_next     = ACQUIRE;
            w_cnt_nxt  = '0;
            w_mc_nxt   = '0;
            w_ferr_set = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_mc           <= '0;
      r_div_q        <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_lock_lost    <= 1'b0;
      r_freq_err     <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_mc           <= w_mc_nxt;
      r_div_q        <= div_num;
      r_period_valid <= w_cap;
      r_lock_lost    <= (r_state == LOCKED) && (w_next != LOCKED);
      if (w_cap) r_period <= r_cnt;
      if (w_next == IDLE)  r_freq_err <= 1'b0;
      else if (w_ferr_set) r_freq_err <= 1'b1;
    end
  end

  assign locked       = (r_state == LOCKED);
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign lock_lost    = r_lock_lost;
  assign freq_err     = r_freq_err;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: cycle-by-cycle comparison against an edge-time
// reference model, a scenario table, and hand-built corner sequences.
module tb_pll_lock_monitor;

  localparam int LOCK_COUNT = 4;
  localparam int TOL        = 1;
  localparam int TIMEOUT    = 64;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] div;
  logic       mon;
  logic       locked;
  logic [7:0] period;
  logic       period_valid;
  logic       lock_lost;
  logic       freq_err;

  int vectors = 0;
  int errors  = 0;

  pll_lock_monitor #(
    .LOCK_COUNT (LOCK_COUNT),
    .TOL        (TOL),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (8)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .enable       (en),
    .div_num      (div),
    .clk_mon      (mon),
    .locked       (locked),
    .period       (period),
    .period_valid (period_valid),
    .lock_lost    (lock_lost),
    .freq_err     (freq_err)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: works from absolute times of detected rising edges.
  bit m_q[$];
  int m_t, m_last, m_good, m_period, m_prev_div;
  bit m_active, m_armed, m_locked, m_pv, m_ll, m_ferr;

  task automatic model_reset();
    m_q = {};
    repeat (4) m_q.push_back(1'b0);
    m_t = 0; m_last = 0; m_good = 0; m_period = 0; m_prev_div = 0;
    m_active = 0; m_armed = 0; m_locked = 0; m_pv = 0; m_ll = 0; m_ferr = 0;
  endtask

  task automatic model_step();
    bit rise, was;
    int d, per, dev;
    m_q.push_back(mon);
    rise = m_q[m_q.size()-4] && !m_q[m_q.size()-5];
    if (m_q.size() > 8) m_q.delete(0);
    d = int'(div);
    was = m_locked;
    m_pv = 0;
    m_t++;
    if (!en || d == 0) begin
      m_active = 0; m_armed = 0; m_locked = 0; m_good = 0; m_ferr = 0;
    end else if (!m_active) begin
      m_active = 1; m_armed = 0;
    end else if (d != m_prev_div) begin
      m_armed = 0; m_locked = 0; m_good = 0;
    end else if (rise) begin
      if (!m_armed) begin
        m_armed = 1; m_last = m_t; m_good = 0;
      end else begin
        per = m_t - m_last;
        m_last = m_t;
        m_pv = 1;
        m_period = per;
        dev = per - 2 * d;
        if (dev < 0) dev = -dev;
        if (dev <= TOL) begin
          m_good++;
          if (m_good >= LOCK_COUNT) m_locked = 1;
        end else begin
          m_good = 0; m_locked = 0; m_ferr = 1;
        end
      end
    end else if (m_armed && (m_t - m_last >= TIMEOUT)) begin
      m_armed = 0; m_locked = 0; m_good = 0; m_ferr = 1;
    end
    m_ll = was && !m_locked;
    m_prev_div = d;
  endtask

  // Observation trackers for the hand-written sequences.
  int n_pv, n_ll, lock_pv, cyc_no, last_pv_cyc, ll_cyc;
  bit prev_locked;

  task automatic clear_trk();
    n_pv = 0; n_ll = 0; lock_pv = -1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    vectors++;
    if ({locked, period, period_valid, lock_lost, freq_err} !==
        {m_locked, 8'(m_period), m_pv, m_ll, m_ferr}) begin
      errors++;
      $display("FAIL cycle %0d outputs: got locked=%0b period=%0d pv=%0b lost=%0b ferr=%0b, want %0b %0d %0b %0b %0b",
               cyc_no, locked, period, period_valid, lock_lost, freq_err,
               m_locked, m_period, m_pv, m_ll, m_ferr);
    end
    cyc_no++;
    if (period_valid === 1'b1) begin n_pv++; last_pv_cyc = cyc_no; end
    if (lock_lost === 1'b1) begin n_ll++; ll_cyc = cyc_no; n_pv = 0; end
    if (locked === 1'b1 && !prev_locked) lock_pv = n_pv;
    prev_locked = (locked === 1'b1);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      mon = 1'b1;
      for (int i = 0; i < hi; i++) cyc();
      mon = 1'b0;
      for (int i = 0; i < lo; i++) cyc();
    end
  endtask

  task automatic idle(input int n);
    mon = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic restart(input int d);
    en = 1'b0;
    div = 3'(d);
    idle(3);
    en = 1'b1;
    clear_trk();
  endtask

  typedef struct {
    int div;
    int hi;
    int lo;
    int per;
    bit lk;
    bit fe;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4, 4, 4,  8, 1'b1, 1'b0};
    tbl[1]  = '{4, 4, 3,  7, 1'b1, 1'b0};
    tbl[2]  = '{4, 3, 3,  6, 1'b0, 1'b1};
    tbl[3]  = '{2, 2, 2,  4, 1'b1, 1'b0};
    tbl[4]  = '{7, 7, 7, 14, 1'b1, 1'b0};
    tbl[5]  = '{1, 1, 1,  2, 1'b1, 1'b0};
    tbl[6]  = '{3, 5, 5, 10, 1'b0, 1'b1};
    tbl[7]  = '{4, 5, 4,  9, 1'b1, 1'b0};
    tbl[8]  = '{4, 5, 5, 10, 1'b0, 1'b1};
    tbl[9]  = '{5, 5, 6, 11, 1'b1, 1'b0};
    tbl[10] = '{6, 6, 4, 10, 1'b0, 1'b1};

    rst_n = 1'b1; en = 1'b0; div = '0; mon = 1'b0;
    cyc_no = 0; last_pv_cyc = 0; ll_cyc = 0; prev_locked = 0;
    clear_trk();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset_locked", locked, 0);
    check("reset_period", period, 0);
    check("reset_pv", period_valid, 0);
    check("reset_lost", lock_lost, 0);
    check("reset_ferr", freq_err, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      restart(tbl[i].div);
      wave(tbl[i].hi, tbl[i].lo, 8);
      idle(4);
      check($sformatf("tbl%0d_period", i), period, tbl[i].per);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      check($sformatf("tbl%0d_ferr", i), freq_err, tbl[i].fe);
    end

    // Lock at period 8, lose it on one period of 11, relock.
    restart(4);
    wave(4, 4, 8);
    check("t1_lock_pv", lock_pv, 4);
    check("t1_locked", locked, 1);
    check("t1_period", period, 8);
    check("t1_ferr", freq_err, 0);
    clear_trk();
    wave(6, 5, 1);
    wave(4, 4, 6);
    idle(4);
    check("t2_lost_pulses", n_ll, 1);
    check("t2_ferr", freq_err, 1);
    check("t2_relock_pv", lock_pv, 4);
    check("t2_locked", locked, 1);

    // Alternating 7/9 accepted, a 6 rejected.
    restart(4);
    for (int i = 0; i < 4; i++) begin
      wave(4, 3, 1);
      wave(4, 5, 1);
    end
    check("t3_locked", locked, 1);
    check("t3_ferr_clean", freq_err, 0);
    wave(3, 3, 1);
    wave(4, 4, 1);
    idle(4);
    check("t3_reject_period", period, 6);
    check("t3_reject_locked", locked, 0);
    check("t3_reject_ferr", freq_err, 1);

    // Static clk_mon while locked: timeout exactly TIMEOUT cycles after the edge.
    restart(4);
    wave(4, 4, 6);
    check("t4_locked", locked, 1);
    clear_trk();
    mon = 1'b0;
    for (int i = 0; i < 120 && n_ll == 0; i++) cyc();
    check("t4_lost_pulses", n_ll, 1);
    check("t4_gap", ll_cyc - last_pv_cyc, TIMEOUT);
    check("t4_ferr", freq_err, 1);
    check("t4_locked", locked, 0);

    // div_num change while locked.
    restart(4);
    wave(4, 4, 6);
    check("t5_locked_before", locked, 1);
    clear_trk();
    div = 3'd2;
    wave(2, 2, 8);
    idle(4);
    check("t5_lost_pulses", n_ll, 1);
    check("t5_ferr", freq_err, 0);
    check("t5_relock_pv", lock_pv, 4);
    check("t5_locked", locked, 1);
    check("t5_period", period, 4);

    // Asynchronous reset mid-MEASURE, then div_num=0 while enabled.
    restart(4);
    wave(4, 4, 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_locked", locked, 0);
    check("t6_rst_period", period, 0);
    check("t6_rst_pv", period_valid, 0);
    check("t6_rst_lost", lock_lost, 0);
    check("t6_rst_ferr", freq_err, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    en = 1'b1;
    div = 3'd0;
    clear_trk();
    wave(2, 2, 10);
    check("t6_div0_pv", n_pv, 0);
    check("t6_div0_locked", locked, 0);

    // Randomized traffic against the model.
    for (int b = 0; b < 120; b++) begin
      int r, half, hi, lo;
      r = $urandom_range(0, 99);
      en = (r >= 5);
      if (r >= 5 && r < 20) div = 3'($urandom_range(0, 7));
      half = (div == 0) ? 2 : int'(div);
      hi = half;
      lo = half;
      if ($urandom_range(0, 9) < 3) begin
        hi = half + $urandom_range(0, 2) - 1;
        lo = half + $urandom_range(0, 2) - 1;
        if (hi < 1) hi = 1;
        if (lo < 1) lo = 1;
      end
      wave(hi, lo, $urandom_range(1, 8));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(40, 80));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
